chirp_result_reader: RTL and testbench

Drains the 512-entry chirp result RAM (modulus entries at addresses 0..255, phase entries at 256..511) once a frequency sweep reports completion. It emits one {phase, modulus} pair per sweep point on a valid/ready stream towards the acquisition/DMA side. It is the reading end of the result buffer written by the ASG channel's chirp control path. It sits in the `dac_clk_i` domain next to that channel and drives the RAM's read port.

---
 rtl/chirp_result_reader_if.sv | 25 ++
 rtl/chirp_result_reader.sv | 136 +++++++++++++
 tb/tb_chirp_result_reader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/chirp_result_reader_if.sv
// Read port of the chirp result RAM plus the {phase, modulus} output stream.
// master = the reader block, slave = the RAM / consumer side.
interface chirp_result_reader_if #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 8
);
    logic                      rd_en_o;
    logic [ADDR_WIDTH:0]       rd_addr_o;
    logic [DATA_WIDTH-1:0]     rd_data_i;
    logic [2*DATA_WIDTH-1:0]   m_data_o;
    logic [ADDR_WIDTH-1:0]     m_index_o;
    logic                      m_valid_o;
    logic                      m_last_o;
    logic                      m_ready_i;

    modport master (
        output rd_en_o, rd_addr_o, m_data_o, m_index_o, m_valid_o, m_last_o,
        input  rd_data_i, m_ready_i
    );

    modport slave (
        input  rd_en_o, rd_addr_o, m_data_o, m_index_o, m_valid_o, m_last_o,
        output rd_data_i, m_ready_i
    );
endinterface

// File: rtl/chirp_result_reader.sv
// Drains the chirp result RAM after a sweep: one modulus and one phase read
// per point, emitted as a {phase, modulus} pair on a valid/ready stream.
module chirp_result_reader #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 8,
    parameter int N_POINTS   = 256
) (
    input  logic                  dac_clk_i,
    input  logic                  dac_rstn_i,
    input  logic                  fin_i,
    input  logic                  abort_i,
    chirp_result_reader_if.master bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overrun_o
);
    typedef enum logic [2:0] {IDLE, RD_MOD, RD_PH, WAIT_PH, OUT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_POINTS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   mod_q, mod_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH:0]     rd_addr_q, rd_addr_d;
    logic [2*DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0]   index_q, index_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic                    ovr_q, ovr_d;

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mod_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            data_q    <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mod_q     <= mod_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            data_q    <= data_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mod_d     = mod_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        data_d    = data_q;
        index_d   = index_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q;

        unique case (state_q)
            IDLE: begin
                if (fin_i) begin
                    idx_d   = '0;
                    state_d = RD_MOD;
                end
            end
            RD_MOD: state_d = RD_PH;
            RD_PH: begin
                mod_d   = bus.rd_data_i;
                state_d = WAIT_PH;
            end
            WAIT_PH: begin
                data_d  = {bus.rd_data_i, mod_q};
                index_d = idx_q;
                last_d  = (idx_q == LAST_IDX);
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (valid_q && bus.m_ready_i) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD_MOD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin_i && state_q != IDLE)
            ovr_d = 1'b1;

        if (abort_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
            ovr_d   = 1'b0;
        end

        // Read port is registered, so it is driven from the state being entered.
        if (state_d == RD_MOD || state_d == RD_PH) begin
            rd_en_d   = 1'b1;
            rd_addr_d = {state_d == RD_PH, idx_d};
        end
    end

    assign bus.rd_en_o   = rd_en_q;
    assign bus.rd_addr_o = rd_addr_q;
    assign bus.m_data_o  = data_q;
    assign bus.m_index_o = index_q;
    assign bus.m_valid_o = valid_q;
    assign bus.m_last_o  = last_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign overrun_o     = ovr_q;
endmodule

// File: tb/tb_chirp_result_reader.sv
// Bench for chirp_result_reader: vector table on a 2-point build, plus
// streaming, backpressure, overrun, abort and async-reset sequences on 256 points.
module tb_chirp_result_reader;
    localparam int DW = 14;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fin = 1'b0, abort = 1'b0, fin2 = 1'b0, abort2 = 1'b0;
    logic busy, done, overrun, busy2, done2, overrun2;
    int   total = 0;
    int   bad = 0;

    chirp_result_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    chirp_result_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    chirp_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_POINTS(256)) dut (
        .dac_clk_i(clk), .dac_rstn_i(rst_n), .fin_i(fin), .abort_i(abort),
        .bus(bus), .busy_o(busy), .done_o(done), .overrun_o(overrun)
    );

    chirp_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_POINTS(2)) dut2 (
        .dac_clk_i(clk), .dac_rstn_i(rst_n), .fin_i(fin2), .abort_i(abort2),
        .bus(bus2), .busy_o(busy2), .done_o(done2), .overrun_o(overrun2)
    );

    always #5 clk = ~clk;

    // Result RAM model: modulus[i]=i, phase[i]=0x3FFF-i, 1-cycle read latency.
    logic [DW-1:0] mem [0:511];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]       = DW'(i);
            mem[256 + i] = DW'(16383 - i);
        end
    end
    always @(posedge clk) if (bus.rd_en_o)  bus.rd_data_i  <= mem[bus.rd_addr_o];
    always @(posedge clk) if (bus2.rd_en_o) bus2.rd_data_i <= mem[bus2.rd_addr_o];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        fin, abort, ready;
        logic        rd_en;
        logic [8:0]  addr;
        logic        valid, last;
        logic [7:0]  index;
        logic [27:0] data;
        logic        busy, done, ovr;
    } vec_t;

    function automatic vec_t mk(input logic f, input logic a, input logic r, input logic en,
                                input logic [8:0] ad, input logic v, input logic l,
                                input logic [7:0] ix, input logic [27:0] d,
                                input logic b, input logic dn, input logic o);
        vec_t t;
        t.fin = f; t.abort = a; t.ready = r; t.rd_en = en; t.addr = ad; t.valid = v;
        t.last = l; t.index = ix; t.data = d; t.busy = b; t.done = dn; t.ovr = o;
        return t;
    endfunction

    task automatic run_stream(input int pct, input int fin_at, input logic expect_ovr);
        int   exp_idx = 0;
        int   cyc = 0;
        logic stalled = 1'b0;
        logic pulsed = 1'b0;
        logic hs;
        logic [37:0] held = '0;
        fin = 1'b1;
        bus.m_ready_i = 1'b0;
        @(posedge clk); #1;
        fin = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        while (!done && cyc < 20000) begin
            fin = 1'b0;
            if (stalled)
                check("stall_hold", 64'({bus.m_valid_o, bus.m_last_o, bus.m_index_o, bus.m_data_o}), 64'(held));
            else if (bus.m_valid_o) begin
                check("pair_index", 64'(bus.m_index_o), 64'(exp_idx));
                check("pair_data", 64'(bus.m_data_o), 64'({DW'(16383 - exp_idx), DW'(exp_idx)}));
                check("pair_last", 64'(bus.m_last_o), 64'(exp_idx == 255));
            end
            hs = ($urandom_range(99, 0) < pct);
            bus.m_ready_i = hs;
            if (bus.m_valid_o && !pulsed && fin_at == int'(bus.m_index_o)) begin
                fin = 1'b1;
                pulsed = 1'b1;
            end
            if (bus.m_valid_o) begin
                if (hs) begin
                    exp_idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = {bus.m_valid_o, bus.m_last_o, bus.m_index_o, bus.m_data_o};
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        fin = 1'b0;
        bus.m_ready_i = 1'b0;
        check("done_seen", 64'(done), 64'(1));
        check("pair_count", 64'(exp_idx), 64'(256));
        if (pct >= 100) check("done_latency", 64'(cyc), 64'(1024));
        check("busy_at_done", 64'(busy), 64'(0));
        check("overrun_at_done", 64'(overrun), 64'(expect_ovr));
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'(0));
        check("overrun_after_done", 64'(overrun), 64'(expect_ovr));
    endtask

    initial begin
        vec_t vt [14];
        logic [27:0] d1, d2;
        logic seen_done;
        int   cyc;
        d1 = {14'h3FFF, 14'h0000};
        d2 = {14'h3FFE, 14'h0001};
        //           fin   abort ready  rd_en addr    valid last  index  data   busy  done  ovr
        vt[0]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 8'd0, 28'h0, 1'b1, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 9'h100, 1'b0, 1'b0, 8'd0, 28'h0, 1'b1, 1'b0, 1'b0);
        vt[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 9'h100, 1'b0, 1'b0, 8'd0, 28'h0, 1'b1, 1'b0, 1'b0);
        vt[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 9'h100, 1'b1, 1'b0, 8'd0, d1,    1'b1, 1'b0, 1'b0);
        vt[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 9'h100, 1'b1, 1'b0, 8'd0, d1,    1'b1, 1'b0, 1'b0);
        vt[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0, 8'd0, d1,    1'b1, 1'b0, 1'b0);
        vt[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 9'h101, 1'b0, 1'b0, 8'd0, d1,    1'b1, 1'b0, 1'b0);
        vt[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 9'h101, 1'b0, 1'b0, 8'd0, d1,    1'b1, 1'b0, 1'b0);
        vt[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 9'h101, 1'b1, 1'b1, 8'd1, d2,    1'b1, 1'b0, 1'b0);
        vt[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 9'h101, 1'b0, 1'b0, 8'd1, d2,    1'b0, 1'b1, 1'b1);
        vt[10] = mk(1'b1, 1'b1, 1'b1, 1'b0, 9'h101, 1'b0, 1'b0, 8'd1, d2,    1'b0, 1'b0, 1'b0);
        vt[11] = mk(1'b1, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 8'd1, d2,    1'b1, 1'b0, 1'b0);
        vt[12] = mk(1'b1, 1'b0, 1'b1, 1'b1, 9'h100, 1'b0, 1'b0, 8'd1, d2,    1'b1, 1'b0, 1'b1);
        vt[13] = mk(1'b0, 1'b1, 1'b1, 1'b0, 9'h100, 1'b0, 1'b0, 8'd1, d2,    1'b0, 1'b0, 1'b0);

        bus.m_ready_i = 1'b0;
        bus2.m_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({bus.rd_en_o, bus.rd_addr_o, bus.m_valid_o, bus.m_last_o, bus.m_index_o,
                                  bus.m_data_o, busy, done, overrun}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2-point build, cycle by cycle
        for (int i = 0; i < 14; i++) begin
            fin2 = vt[i].fin;
            abort2 = vt[i].abort;
            bus2.m_ready_i = vt[i].ready;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  64'({bus2.rd_en_o, bus2.rd_addr_o, bus2.m_valid_o, bus2.m_last_o, bus2.m_index_o,
                       bus2.m_data_o, busy2, done2, overrun2}),
                  64'({vt[i].rd_en, vt[i].addr, vt[i].valid, vt[i].last, vt[i].index,
                       vt[i].data, vt[i].busy, vt[i].done, vt[i].ovr}));
        end
        fin2 = 1'b0;
        abort2 = 1'b0;

        run_stream(100, -1, 1'b0);
        run_stream(30, 10, 1'b1);

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_clears_overrun", 64'(overrun), 64'(0));

        // abort while holding index 100 unaccepted
        fin = 1'b1;
        bus.m_ready_i = 1'b1;
        @(posedge clk); #1;
        fin = 1'b0;
        cyc = 0;
        while (!(bus.m_valid_o && bus.m_index_o == 8'd100) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.m_ready_i = 1'b0;
        check("abort_reach_idx100", 64'({bus.m_valid_o, bus.m_index_o}), 64'({1'b1, 8'd100}));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_outputs", 64'({bus.m_valid_o, bus.m_last_o, bus.rd_en_o, busy, done}), 64'(0));
        seen_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen_done = seen_done | done | busy;
        end
        check("abort_stays_idle", 64'(seen_done), 64'(0));
        run_stream(100, -1, 1'b0);

        // asynchronous reset while at index 50
        fin = 1'b1;
        bus.m_ready_i = 1'b1;
        @(posedge clk); #1;
        fin = 1'b0;
        cyc = 0;
        while (!(bus.m_valid_o && bus.m_index_o == 8'd50) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reset_reach_idx50", 64'({bus.m_valid_o, bus.m_index_o}), 64'({1'b1, 8'd50}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({bus.rd_en_o, bus.rd_addr_o, bus.m_valid_o, bus.m_last_o, bus.m_index_o,
                   bus.m_data_o, busy, done, overrun}), 64'(0));
        bus.m_ready_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 64'({busy, bus.m_valid_o}), 64'(0));
        run_stream(100, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
